// File: rtl/bist_pkg.sv
// Shared definitions for the BIST controller: FSM state encoding, pattern
// LFSR taps and the signature start value.
package bist_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StCheck,
        StDone
    } bist_state_e;

    // x^4 + x + 1: feedback is p[3] ^ p[0], shifted in at the LSB.
    localparam logic [3:0] LFSR_TAPS = 4'b1001;

    // Signature register value after reset and at the start of every run.
    localparam logic [3:0] SIG_INIT = 4'b0001;

endpackage

// File: rtl/bist_tpg.sv
// Test pattern generator for the BIST controller.
// Default build: maximal-length LFSR seeded with SEED.
// With BIST_COUNTER_TPG_EN defined: binary up-counter starting at 0.
module bist_tpg
    import bist_pkg::*;
#(
    parameter int unsigned       WIDTH = 4,
    parameter logic [WIDTH-1:0]  SEED  = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             enable,
    output logic [WIDTH-1:0] pattern
);

    logic [WIDTH-1:0] pattern_q;
    logic [WIDTH-1:0] pattern_d;
    logic [WIDTH-1:0] init_val;
    logic [WIDTH-1:0] next_val;

`ifdef BIST_COUNTER_TPG_EN
    assign init_val = '0;
    assign next_val = pattern_q + WIDTH'(1);
`else
    localparam logic [WIDTH-1:0] TAPS = WIDTH'(LFSR_TAPS);
    assign init_val = SEED;
    assign next_val = {pattern_q[WIDTH-2:0], ^(pattern_q & TAPS)};
`endif

    // Load wins over advance; otherwise the generator holds its value.
    always_comb begin
        pattern_d = pattern_q;
        if (load) begin
            pattern_d = init_val;
        end else if (enable) begin
            pattern_d = next_val;
        end
    end

    // Pattern register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern_q <= init_val;
        end else begin
            pattern_q <= pattern_d;
        end
    end

    assign pattern = pattern_q;

endmodule

// File: rtl/bist_controller.sv
// BIST controller: applies PATTERN_COUNT patterns, compacts the serial
// response into a signature register and compares it against GOLDEN.
// Optional build macro BIST_COUNTER_TPG_EN swaps the LFSR pattern
// generator for a binary counter; signature, FSM and timing are unchanged.
module bist_controller
    import bist_pkg::*;
#(
    parameter int unsigned      WIDTH         = 4,
    parameter int unsigned      PATTERN_COUNT = 15,
    parameter logic [WIDTH-1:0] SEED          = 4'b0001,
    parameter logic [WIDTH-1:0] GOLDEN        = 4'hA
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             resp_in,
    output logic [WIDTH-1:0] pattern,
    output logic [WIDTH-1:0] signature,
    output logic             busy,
    output logic             done,
    output logic             pass
);

    // Sized to hold PATTERN_COUNT itself so the terminal compare never wraps.
    localparam int unsigned CNT_W = (PATTERN_COUNT < 2) ? 1 : $clog2(PATTERN_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PATTERN_COUNT);
    localparam logic [WIDTH-1:0] SIG_RST  = WIDTH'(SIG_INIT);

    bist_state_e      state_q, state_d;
    logic [WIDTH-1:0] sig_q, sig_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pass_q, pass_d;
    logic             tpg_load;
    logic             tpg_en;

    bist_tpg #(
        .WIDTH (WIDTH),
        .SEED  (SEED)
    ) u_tpg (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (tpg_load),
        .enable  (tpg_en),
        .pattern (pattern)
    );

    // Next-state, signature compaction, pattern count and verdict.
    always_comb begin
        state_d  = state_q;
        sig_d    = sig_q;
        cnt_d    = cnt_q;
        pass_d   = pass_q;
        tpg_load = 1'b0;
        tpg_en   = 1'b0;
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d  = StRun;
                    sig_d    = SIG_RST;
                    cnt_d    = '0;
                    pass_d   = 1'b0;
                    tpg_load = 1'b1;
                end
            end
            StRun: begin
                sig_d  = {sig_q[WIDTH-2:0], sig_q[1] ^ resp_in};
                tpg_en = 1'b1;
                cnt_d  = cnt_q + CNT_W'(1);
                // Leave on the edge that absorbs the last response bit.
                if (cnt_d == CNT_LAST) begin
                    state_d = StCheck;
                end
            end
            StCheck: begin
                pass_d  = (sig_q == GOLDEN);
                state_d = StDone;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, signature, count and verdict registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sig_q   <= SIG_RST;
            cnt_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
        end
    end

    assign signature = sig_q;
    assign busy      = (state_q == StRun) || (state_q == StCheck);
    assign done      = (state_q == StDone);
    assign pass      = pass_q;

endmodule

// File: tb/tb_bist_controller.sv
// Directed self-checking bench for bist_controller.
// Expected patterns follow the build: LFSR by default, counter when
// BIST_COUNTER_TPG_EN is defined.
module tb_bist_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       resp_in = 1'b0;
    logic [3:0] pattern, signature, pattern_b, signature_b;
    logic       busy, done, pass, busy_b, done_b, pass_b;

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0] pats[15];
    logic [3:0] exp_pat[15];
    logic [3:0] lfsr_tab[15];
    logic       done_after_e1;
    int         lat, nbusy;

`ifdef BIST_COUNTER_TPG_EN
    localparam logic [3:0] PAT_RST = 4'h0;
    localparam logic [3:0] PAT_END = 4'hF;
`else
    localparam logic [3:0] PAT_RST = 4'h1;
    localparam logic [3:0] PAT_END = 4'h1;
`endif

    always #5 clk = ~clk;

    bist_controller #(
        .WIDTH         (4),
        .PATTERN_COUNT (15),
        .SEED          (4'b0001),
        .GOLDEN        (4'hA)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .resp_in   (resp_in),
        .pattern   (pattern),
        .signature (signature),
        .busy      (busy),
        .done      (done),
        .pass      (pass)
    );

    bist_controller #(
        .WIDTH         (4),
        .PATTERN_COUNT (15),
        .SEED          (4'b0001),
        .GOLDEN        (4'h5)
    ) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .resp_in   (resp_in),
        .pattern   (pattern_b),
        .signature (signature_b),
        .busy      (busy_b),
        .done      (done_b),
        .pass      (pass_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Start is driven just after "edge 0" and sampled at edge 1; lat is the
    // edge index at which done is first seen (0 on timeout).
    task automatic do_run(input logic resp, input int repulse_at,
                          output int lat_o, output int nbusy_o);
        start   = 1'b1;
        resp_in = resp;
        lat_o   = 0;
        nbusy_o = 0;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            #1;
            if (e == 1) begin
                start = 1'b0;
                done_after_e1 = done;
            end
            if (e == repulse_at) start = 1'b1;
            else if (e == repulse_at + 1) start = 1'b0;
            if (busy) begin
                if (nbusy_o < 15) pats[nbusy_o] = pattern;
                nbusy_o++;
            end
            if (done) begin
                lat_o = e;
                break;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        lfsr_tab = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hD, 4'hA, 4'h5,
                     4'hB, 4'h6, 4'hC, 4'h9, 4'h2, 4'h4, 4'h8};
        for (int i = 0; i < 15; i++) begin
`ifdef BIST_COUNTER_TPG_EN
            exp_pat[i] = 4'(i);
`else
            exp_pat[i] = lfsr_tab[i];
`endif
        end

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_pattern", 32'(pattern), 32'(PAT_RST));
        check_eq("rst_signature", 32'(signature), 32'h1);
        check_eq("rst_busy", 32'(busy), 32'h0);
        check_eq("rst_done", 32'(done), 32'h0);
        check_eq("rst_pass", 32'(pass), 32'h0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("idle_busy", 32'(busy), 32'h0);

        // Run 1: resp_in = 0 -> signature A; pass on GOLDEN=A, fail on GOLDEN=5
        do_run(1'b0, 0, lat, nbusy);
        check_eq("r1_latency", 32'(lat), 32'd17);
        check_eq("r1_busy_cycles", 32'(nbusy), 32'd16);
        check_eq("r1_signature", 32'(signature), 32'hA);
        check_eq("r1_pass", 32'(pass), 32'h1);
        check_eq("r1_b_signature", 32'(signature_b), 32'hA);
        check_eq("r1_b_done", 32'(done_b), 32'h1);
        check_eq("r1_b_pass", 32'(pass_b), 32'h0);
        for (int i = 0; i < 15; i++) begin
            check_eq($sformatf("r1_pattern[%0d]", i), 32'(pats[i]), 32'(exp_pat[i]));
        end
        repeat (3) @(posedge clk);
        #1;
        check_eq("r1_hold_done", 32'(done), 32'h1);
        check_eq("r1_hold_busy", 32'(busy), 32'h0);
        check_eq("r1_hold_pattern", 32'(pattern), 32'(PAT_END));
        check_eq("r1_hold_signature", 32'(signature), 32'hA);

        // Run 2: restart from DONE, resp_in = 1 -> signature C, fails both
        do_run(1'b1, 0, lat, nbusy);
        check_eq("r2_done_dropped", 32'(done_after_e1), 32'h0);
        check_eq("r2_latency", 32'(lat), 32'd17);
        check_eq("r2_signature", 32'(signature), 32'hC);
        check_eq("r2_pass", 32'(pass), 32'h0);
        check_eq("r2_b_pass", 32'(pass_b), 32'h0);

        // Run 3: start re-pulsed mid-run is ignored
        do_run(1'b0, 6, lat, nbusy);
        check_eq("r3_latency", 32'(lat), 32'd17);
        check_eq("r3_busy_cycles", 32'(nbusy), 32'd16);
        check_eq("r3_signature", 32'(signature), 32'hA);
        check_eq("r3_pass", 32'(pass), 32'h1);

        // Run 4: asynchronous reset in RUN cycle 5
        start   = 1'b1;
        resp_in = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_busy", 32'(busy), 32'h0);
        check_eq("mid_rst_done", 32'(done), 32'h0);
        check_eq("mid_rst_pass", 32'(pass), 32'h0);
        check_eq("mid_rst_pattern", 32'(pattern), 32'(PAT_RST));
        check_eq("mid_rst_signature", 32'(signature), 32'h1);
        @(negedge clk) rst_n = 1'b1;
        do_run(1'b0, 0, lat, nbusy);
        check_eq("r4_latency", 32'(lat), 32'd17);
        check_eq("r4_signature", 32'(signature), 32'hA);
        check_eq("r4_pass", 32'(pass), 32'h1);

        // Run 5: start held through reset release is taken on the first edge
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b1;
        resp_in = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_eq("held_start_busy", 32'(busy), 32'h1);
        lat = 0;
        for (int e = 2; e <= 40; e++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = e;
                break;
            end
        end
        check_eq("r5_latency", 32'(lat), 32'd17);
        check_eq("r5_signature", 32'(signature), 32'hA);
        check_eq("r5_pass", 32'(pass), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bist_controller.md
BIST_CONTROLLER -- requirements
Module: bist_controller

Interface
REQ-001 SHALL have parameter WIDTH, default 4, the pattern and signature width.
REQ-002 SHALL have parameter PATTERN_COUNT, default 15, the number of patterns applied per run (range 1..2**WIDTH-1).
REQ-003 SHALL have parameter SEED, default 4'b0001, the non-zero pattern LFSR start value.
REQ-004 SHALL have parameter GOLDEN, default 4'hA, the expected final signature.
REQ-005 SHALL have port clk, input, 1 bit, the single clock (rising edge).
REQ-006 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-007 SHALL have port start, input, 1 bit, run request, sampled in IDLE or DONE only.
REQ-008 SHALL have port resp_in, input, 1 bit, serial response bit from the circuit under test.
REQ-009 SHALL have port pattern, output, WIDTH bits, the stimulus to the circuit under test.
REQ-010 SHALL have port signature, output, WIDTH bits, the current signature register.
REQ-011 SHALL have outputs busy, done and pass, 1 bit each: run active, result valid, and signature matched GOLDEN.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, CHECK and DONE.
REQ-013 SHALL, when start=1 in IDLE or DONE, load pattern<=SEED, signature<=4'b0001 and count<=0, clear done and pass, and enter RUN.
REQ-014 SHALL, on each RUN edge, update signature<={sig[2:0], sig[1]^resp_in}, advance the pattern and increment count.
REQ-015 SHALL advance the pattern LFSR as {p[2:0], p[3]^p[0]} (x^4+x+1, maximal length), giving 0001,0011,0111,1111,1110,... from SEED=0001.
REQ-016 SHALL leave RUN for CHECK on the edge where count reaches PATTERN_COUNT, so that exactly PATTERN_COUNT resp_in bits are absorbed.
REQ-017 SHALL, in CHECK (one cycle), register pass<=(signature==GOLDEN) and enter DONE.
REQ-018 SHALL assert busy=1 in RUN and CHECK; done=1 only in DONE; pass is valid only while done=1.
REQ-019 SHALL give a start-to-done latency of PATTERN_COUNT+2 cycles (start sampled at edge 0, done=1 after edge PATTERN_COUNT+2).
REQ-020 SHALL ignore start while busy=1; a start in DONE restarts the run immediately (done drops on the next edge).
REQ-021 SHALL hold pattern and signature frozen in CHECK, DONE and IDLE.
REQ-022 SHALL make the count wide enough for PATTERN_COUNT so that it never wraps.

Reset
REQ-023 SHALL, on rst_n=0 at any time including mid-run, set state=IDLE, pattern=SEED, signature=4'b0001, count=0 and busy=done=pass=0.
REQ-024 SHALL resume operation only on a start after rst_n deasserts; a start held through reset release is sampled on the first clock edge.

Configuration
REQ-025 SHALL provide macro BIST_COUNTER_TPG_EN; when defined, pattern is a binary up-counter from 0 (0,1,2,...) wrapping modulo 2**WIDTH.
REQ-026 SHALL, with BIST_COUNTER_TPG_EN undefined, use the LFSR pattern generator of REQ-015; the signature, FSM and timing are identical in both builds.

Structure
REQ-027 SHALL place the FSM state enum, the LFSR tap constant and the signature reset value 4'b0001 in shared package bist_pkg.
REQ-028 SHALL implement the pattern generator as sub-module bist_tpg (load, enable, pattern out), with the macro selecting its internals.

Verification
REQ-029 SHALL cover: resp_in=0, PATTERN_COUNT=15, GOLDEN=4'hA, start pulse -> busy for 16 cycles, then done=1, pass=1, signature=4'hA.
REQ-030 SHALL cover: the same stimulus with GOLDEN=4'h5 -> done=1, pass=0, signature=4'hA.
REQ-031 SHALL cover: LFSR build, pattern sampled over 15 RUN cycles -> 15 distinct non-zero values starting 0001,0011,0111,1111.
REQ-032 SHALL cover: rst_n=0 asserted at RUN cycle 5 -> outputs immediately IDLE-state, pattern=0001, signature=0001; a new start then completes normally.
REQ-033 SHALL cover: start re-pulsed during RUN -> ignored, done still at start+17; start pulsed in DONE -> done=0 next cycle and the new run completes.
REQ-034 SHALL cover: BIST_COUNTER_TPG_EN defined -> pattern 0,1,2,...,14 during RUN, with the signature result matching the LFSR-build case for identical resp_in.
